// File: rtl/dsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dsm_pkg
//  Description : Shared types and helpers for the second-order 1-bit
//                delta-sigma modulator: FSM state encoding, LFSR seed and
//                feedback taps, wide arithmetic type and saturating clamp.
//  Revision    : 1.0 - initial release
// ============================================================================
package dsm_pkg;

  // FSM state encoding; values are visible on state_o.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RECOVER = 2'd2
  } dsm_state_e;

  // LFSR x^16+x^14+x^13+x^11+1, shift-left Fibonacci form: the feedback bit
  // is the parity of register bits 15, 13, 12 and 10.
  localparam logic [15:0] c_lfsr_seed = 16'hACE1;
  localparam logic [15:0] c_lfsr_taps = 16'hB400;

  // Datapath sums are formed in this width so that the unsaturated result of
  // an integrator update never wraps before it is clamped (ACC_W <= 29).
  localparam int c_wide_w = 32;
  typedef logic signed [c_wide_w-1:0] wide_t;

  // Clamp x to the signed range of an acc_w-bit integrator.
  function automatic wide_t sat(input wide_t x, input int acc_w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (acc_w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end else begin
      return x;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/dsm_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : dsm_lfsr16
//  Description : Free-running 16-bit Fibonacci LFSR used as the dither source.
//                Advances on every clock; reset loads the fixed seed.
//  Ports       : clock   - system clock
//                reset_n - asynchronous reset, active-low
//                lfsr_o  - current register contents
//  Revision    : 1.0 - initial release
// ============================================================================
module dsm_lfsr16
  import dsm_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  output logic [15:0] lfsr_o
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb   = ^(r_lfsr & c_lfsr_taps);
  assign lfsr_o = r_lfsr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= c_lfsr_seed;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

endmodule
`default_nettype wire

// File: rtl/dsm2_modulator.sv
`default_nettype none
// ============================================================================
//  Module      : dsm2_modulator
//  Description : Second-order, 1-bit delta-sigma modulator with saturating
//                integrators, overload detection / recovery and optional
//                LFSR dither at the quantizer.
//  Ports       : clock        - system clock
//                reset_n      - asynchronous reset, active-low
//                en_i         - 1 = modulate, 0 = idle toggle pattern
//                dither_en_i  - 1 = add LFSR dither before the quantizer
//                v_in         - signed input sample, one per clock
//                bit_o        - modulator bitstream
//                state_o      - FSM state (IDLE=0, RUN=1, RECOVER=2)
//                ovl_o        - high while in RECOVER
//                ovl_events_o - overload trip count, saturating at 255
//  Revision    : 1.0 - initial release
// ============================================================================
module dsm2_modulator
  import dsm_pkg::*;
#(
  parameter int IN_W      = 20,
  parameter int ACC_W     = 24,
  parameter int OVL_LIMIT = 64,
  parameter int RECOV_CYC = 32,
  parameter int DITH_W    = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   en_i,
  input  logic                   dither_en_i,
  input  logic signed [IN_W-1:0] v_in,
  output logic                   bit_o,
  output logic [1:0]             state_o,
  output logic                   ovl_o,
  output logic [7:0]             ovl_events_o
);

  localparam int SAT_W = (OVL_LIMIT > 2) ? $clog2(OVL_LIMIT) : 1;
  localparam int REC_W = (RECOV_CYC > 2) ? $clog2(RECOV_CYC) : 1;

  localparam wide_t            c_fs        = wide_t'(1) <<< (IN_W - 1);
  localparam wide_t            c_dith_off  = wide_t'(1) <<< (DITH_W - 1);
  localparam logic [SAT_W-1:0] c_sat_last  = SAT_W'(OVL_LIMIT - 1);
  localparam logic [REC_W-1:0] c_rec_last  = REC_W'(RECOV_CYC - 1);

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic signed [ACC_W-1:0] r_int1;
  logic signed [ACC_W-1:0] r_int2;
  logic                    r_bit;
  dsm_state_e              r_state;
  logic                    r_ovl;
  logic [7:0]              r_events;
  logic [SAT_W-1:0]        r_sat_cnt;
  logic [REC_W-1:0]        r_rec_cnt;

  // --------------------------------------------------------------------------
  // Dither source
  // --------------------------------------------------------------------------
  logic [15:0] w_lfsr;
  logic        w_lfsr_unused;

  dsm_lfsr16 u_lfsr (
    .clock   (clock),
    .reset_n (reset_n),
    .lfsr_o  (w_lfsr)
  );

  // Only the low DITH_W bits feed the quantizer.
  assign w_lfsr_unused = ^w_lfsr[15:DITH_W];

  // --------------------------------------------------------------------------
  // Loop arithmetic (all in the wide type, then clamped)
  // --------------------------------------------------------------------------
  wide_t w_vin;
  wide_t w_i1;
  wide_t w_i2;
  wide_t w_fb;
  wide_t w_sum1;
  wide_t w_sum2;
  wide_t w_n1;
  wide_t w_n2;
  wide_t w_dith;
  wide_t w_q;
  logic  w_qbit;
  logic  w_clamp;
  logic  w_trip;

  assign w_vin = {{(c_wide_w - IN_W){v_in[IN_W-1]}}, v_in};
  assign w_i1  = {{(c_wide_w - ACC_W){r_int1[ACC_W-1]}}, r_int1};
  assign w_i2  = {{(c_wide_w - ACC_W){r_int2[ACC_W-1]}}, r_int2};

  // Feedback comes from the registered output bit.
  assign w_fb = r_bit ? c_fs : -c_fs;

  // The second integrator sees the old first-integrator value: this is the
  // delay in the first loop path.
  assign w_sum1 = w_i1 + w_vin - w_fb;
  assign w_sum2 = w_i2 + w_i1 - (w_fb <<< 1);

  assign w_n1 = sat(w_sum1, ACC_W);
  assign w_n2 = sat(w_sum2, ACC_W);

  assign w_clamp = (w_n1 != w_sum1) || (w_n2 != w_sum2);

  // Dither is the LFSR low bits taken as unsigned, re-centred around zero.
  assign w_dith = $signed({{(c_wide_w - DITH_W){1'b0}}, w_lfsr[DITH_W-1:0]}) - c_dith_off;
  assign w_q    = w_n2 + (dither_en_i ? w_dith : wide_t'(0));
  assign w_qbit = (w_q >= wide_t'(0));

  // Trip on the cycle that completes OVL_LIMIT consecutive clamped updates.
  assign w_trip = (r_state == RUN) && w_clamp && (r_sat_cnt == c_sat_last);

  // --------------------------------------------------------------------------
  // Datapath + FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_int1    <= '0;
      r_int2    <= '0;
      r_bit     <= 1'b0;
      r_state   <= IDLE;
      r_ovl     <= 1'b0;
      r_events  <= '0;
      r_sat_cnt <= '0;
      r_rec_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_int1    <= '0;
          r_int2    <= '0;
          r_bit     <= ~r_bit;
          r_ovl     <= 1'b0;
          r_sat_cnt <= '0;
          r_rec_cnt <= '0;
          if (en_i) begin
            r_state <= RUN;
          end
        end

        RUN: begin
          // A trip is logged even when en_i drops in the same cycle.
          if (w_trip && (r_events != 8'hFF)) begin
            r_events <= r_events + 8'd1;
          end
          if (!en_i) begin
            r_int1    <= '0;
            r_int2    <= '0;
            r_bit     <= ~r_bit;
            r_sat_cnt <= '0;
            r_state   <= IDLE;
          end else if (w_trip) begin
            r_int1    <= '0;
            r_int2    <= '0;
            r_bit     <= ~r_bit;
            r_sat_cnt <= '0;
            r_rec_cnt <= '0;
            r_ovl     <= 1'b1;
            r_state   <= RECOVER;
          end else begin
            r_int1    <= w_n1[ACC_W-1:0];
            r_int2    <= w_n2[ACC_W-1:0];
            r_bit     <= w_qbit;
            r_sat_cnt <= w_clamp ? (r_sat_cnt + 1'b1) : '0;
          end
        end

        RECOVER: begin
          r_int1    <= '0;
          r_int2    <= '0;
          r_bit     <= ~r_bit;
          r_sat_cnt <= '0;
          if (!en_i) begin
            r_ovl     <= 1'b0;
            r_rec_cnt <= '0;
            r_state   <= IDLE;
          end else if (r_rec_cnt == c_rec_last) begin
            r_ovl     <= 1'b0;
            r_rec_cnt <= '0;
            r_state   <= RUN;
          end else begin
            r_rec_cnt <= r_rec_cnt + 1'b1;
          end
        end

        default: begin
          r_int1    <= '0;
          r_int2    <= '0;
          r_ovl     <= 1'b0;
          r_sat_cnt <= '0;
          r_rec_cnt <= '0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign bit_o        = r_bit;
  assign state_o      = r_state;
  assign ovl_o        = r_ovl;
  assign ovl_events_o = r_events;

endmodule
`default_nettype wire
